// File: rtl/lock_pkg.sv
// Shared types and constants for the multi-slot lock controller.
// Pure declarations, no logic.
// No flow control: constants only.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

    localparam logic [3:0] DIGIT_ERR   = 4'hE;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/lockout_timer.sv
// Lockout interval timer with LED flasher.
// active/led rise on the edge after start; active stays high exactly LOCK_CYC cycles.
// No backpressure: start is a one-cycle pulse, done marks the final active cycle.
module lockout_timer #(
    parameter int LOCK_CYC   = 1000,
    parameter int FLASH_HALF = 50
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    output logic active,
    output logic led,
    output logic done
);

    localparam int CW = $clog2(LOCK_CYC + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam logic [CW-1:0] CYC_LAST   = CW'(LOCK_CYC - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    logic [CW-1:0] cyc;
    logic [FW-1:0] fcnt;

    // done lets the controller leave lockout on the same edge active drops
    assign done = active && (cyc == CYC_LAST);

    // Interval counter plus half-period counter; LED starts lit on entry
    always_ff @(posedge clk) begin
        if (clr) begin
            active <= 1'b0;
            led    <= 1'b0;
            cyc    <= '0;
            fcnt   <= '0;
        end else if (start) begin
            active <= 1'b1;
            led    <= 1'b1;
            cyc    <= '0;
            fcnt   <= '0;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
                led    <= 1'b0;
                cyc    <= '0;
                fcnt   <= '0;
            end else begin
                cyc <= cyc + CW'(1);
                if (fcnt == FLASH_LAST) begin
                    fcnt <= '0;
                    led  <= ~led;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_slot_lock_controller.sv
// Keypad lock: N-digit entry buffer, K password slots, error counting and timed lockout.
// disp/set pulses one cycle after the strobe; unlock/lockout/err_cnt two cycles after enter.
// No backpressure: strobes arriving in CHECK or LOCKOUT are dropped, keys beyond DIGITS ignored.
module multi_slot_lock_controller
    import lock_pkg::*;
#(
    parameter int DIGITS     = 6,
    parameter int SLOTS      = 4,
    parameter int MAX_ERR    = 3,
    parameter int LOCK_CYC   = 1000,
    parameter int FLASH_HALF = 50,
    localparam int SEL_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                mode,
    input  logic [SEL_W-1:0]    slot_sel,
    input  logic                key_valid,
    input  logic [3:0]          key_in,
    input  logic                enter,
    input  logic                cancel,
    output logic [DIGITS*4-1:0] disp,
    output logic                unlocked,
    output logic                set_ok,
    output logic                set_rej,
    output logic [3:0]          err_cnt,
    output logic                locked_out,
    output logic                led
);

    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [3:0]    ERR_MAX  = 4'(MAX_ERR);
    localparam logic [3:0]    ERR_LAST = 4'(MAX_ERR - 1);

    state_t          state, nstate;
    logic [BW-1:0]   ent_buf;
    logic [CW-1:0]   cnt;
    logic            bad;
    logic [BW-1:0]   slot_mem [SLOTS];
    logic [SLOTS-1:0] slot_vld;

    logic buf_clr, buf_shift, slot_wr, ok_n, rej_n;
    logic err_clr, err_inc, tmr_start, tmr_active, tmr_done;
    logic full, entry_ok, any_hit, match, sel_ok, sel_free;
    logic [3:0] key_dig;

    assign full     = (cnt == CNT_FULL);
    assign entry_ok = full && !bad;
    assign key_dig  = (key_in > 4'd9) ? DIGIT_ERR : key_in;
    assign sel_ok   = (int'(slot_sel) < SLOTS);
    assign sel_free = sel_ok && !slot_vld[slot_sel];

    // Parallel compare of the buffer against every valid slot
    always_comb begin
        any_hit = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_vld[i] && (slot_mem[i] == ent_buf)) any_hit = 1'b1;
        end
        match = any_hit && entry_ok;
    end

    // Next-state and strobe decode; cancel beats enter, enter beats key_valid
    always_comb begin
        nstate    = state;
        buf_clr   = 1'b0;
        buf_shift = 1'b0;
        slot_wr   = 1'b0;
        ok_n      = 1'b0;
        rej_n     = 1'b0;
        err_clr   = 1'b0;
        err_inc   = 1'b0;
        tmr_start = 1'b0;
        case (state)
            ST_IDLE, ST_OPEN: begin
                if (cancel) begin
                    buf_clr = 1'b1;
                end else if (enter) begin
                    if (!mode) begin
                        // Overwriting a valid slot is only allowed while open
                        buf_clr = 1'b1;
                        if (entry_ok && ((state == ST_OPEN) ? sel_ok : sel_free)) begin
                            slot_wr = 1'b1;
                            ok_n    = 1'b1;
                        end else begin
                            rej_n = 1'b1;
                        end
                    end else if (state == ST_IDLE) begin
                        nstate = ST_CHECK;
                    end else if (cnt == '0) begin
                        nstate = ST_IDLE;
                    end
                end else if (key_valid && !full) begin
                    buf_shift = 1'b1;
                end
            end
            ST_CHECK: begin
                buf_clr = 1'b1;
                if (match) begin
                    err_clr = 1'b1;
                    nstate  = ST_OPEN;
                end else begin
                    err_inc = 1'b1;
                    if (err_cnt >= ERR_LAST) begin
                        nstate    = ST_LOCKOUT;
                        tmr_start = 1'b1;
                    end else begin
                        nstate = ST_IDLE;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    nstate  = ST_IDLE;
                    err_clr = 1'b1;
                end
            end
            default: nstate = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= nstate;
    end

    // Entry buffer: shift left, newest digit in the low nibble
    always_ff @(posedge clk) begin
        if (clr || buf_clr) begin
            ent_buf <= {DIGITS{DIGIT_BLANK}};
            cnt     <= '0;
            bad     <= 1'b0;
        end else if (buf_shift) begin
            ent_buf <= {ent_buf[BW-5:0], key_dig};
            cnt     <= cnt + CW'(1);
            if (key_in > 4'd9) bad <= 1'b1;
        end
    end

    // Password store
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < SLOTS; i++) slot_mem[i] <= '0;
            slot_vld <= '0;
        end else if (slot_wr) begin
            slot_mem[slot_sel] <= ent_buf;
            slot_vld[slot_sel] <= 1'b1;
        end
    end

    // Consecutive failure count (saturating) and one-cycle set result pulses
    always_ff @(posedge clk) begin
        if (clr) begin
            err_cnt <= '0;
            set_ok  <= 1'b0;
            set_rej <= 1'b0;
        end else begin
            set_ok  <= ok_n;
            set_rej <= rej_n;
            if (err_clr)                          err_cnt <= '0;
            else if (err_inc && err_cnt < ERR_MAX) err_cnt <= err_cnt + 4'd1;
        end
    end

    lockout_timer #(
        .LOCK_CYC   (LOCK_CYC),
        .FLASH_HALF (FLASH_HALF)
    ) u_timer (
        .clk    (clk),
        .clr    (clr),
        .start  (tmr_start),
        .active (tmr_active),
        .led    (led),
        .done   (tmr_done)
    );

    assign disp       = ent_buf;
    assign unlocked   = (state == ST_OPEN);
    assign locked_out = (state == ST_LOCKOUT) && tmr_active;

endmodule

// File: tb/tb_multi_slot_lock_controller.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random run vs. model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Bounded loops only; always ends with the summary line.
module tb_multi_slot_lock_controller;

    localparam int DIGITS     = 6;
    localparam int SLOTS      = 4;
    localparam int MAX_ERR    = 3;
    localparam int LOCK_CYC   = 40;
    localparam int FLASH_HALF = 5;

    localparam int P_IDLE  = 0;
    localparam int P_CHECK = 1;
    localparam int P_OPEN  = 2;
    localparam int P_LOCK  = 3;

    logic        clk = 1'b0;
    logic        clr = 1'b0, mode = 1'b0, key_valid = 1'b0, enter = 1'b0, cancel = 1'b0;
    logic [1:0]  slot_sel = 2'd0;
    logic [3:0]  key_in = 4'd0;
    logic [23:0] disp;
    logic        unlocked, set_ok, set_rej, locked_out, led;
    logic [3:0]  err_cnt;

    always #5 clk = ~clk;

    multi_slot_lock_controller #(
        .DIGITS(DIGITS), .SLOTS(SLOTS), .MAX_ERR(MAX_ERR),
        .LOCK_CYC(LOCK_CYC), .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk), .clr(clr), .mode(mode), .slot_sel(slot_sel),
        .key_valid(key_valid), .key_in(key_in), .enter(enter), .cancel(cancel),
        .disp(disp), .unlocked(unlocked), .set_ok(set_ok), .set_rej(set_rej),
        .err_cnt(err_cnt), .locked_out(locked_out), .led(led)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    int          m_phase = P_IDLE;
    int          q[$];
    logic [23:0] m_code [SLOTS];
    bit          m_vld  [SLOTS];
    int          m_err = 0, m_elapsed = 0;
    bit          m_ok = 0, m_rej = 0;

    function automatic logic [23:0] m_pack();
        logic [23:0] r;
        int          d;
        r = '1;
        for (int i = 0; i < q.size(); i++) begin
            d = q[q.size() - 1 - i];
            r[4*i +: 4] = d[3:0];
        end
        return r;
    endfunction

    task automatic model_step(input logic c, input logic md, input logic [1:0] sl,
                              input logic kv, input logic [3:0] k, input logic en, input logic ca);
        bit          full, bad, hit;
        logic [23:0] cur;
        m_ok  = 0;
        m_rej = 0;
        if (c) begin
            m_phase = P_IDLE; q.delete(); m_err = 0; m_elapsed = 0;
            for (int s = 0; s < SLOTS; s++) begin m_vld[s] = 0; m_code[s] = '0; end
            return;
        end
        full = (q.size() == DIGITS);
        bad  = 0;
        foreach (q[i]) if (q[i] == 14) bad = 1;
        cur = m_pack();
        case (m_phase)
            P_IDLE, P_OPEN: begin
                if (ca) q.delete();
                else if (en) begin
                    if (!md) begin
                        if ((m_phase == P_OPEN || !m_vld[sl]) && full && !bad) begin
                            m_code[sl] = cur; m_vld[sl] = 1; m_ok = 1;
                        end else m_rej = 1;
                        q.delete();
                    end else if (m_phase == P_IDLE) m_phase = P_CHECK;
                    else if (q.size() == 0) m_phase = P_IDLE;
                end else if (kv && q.size() < DIGITS) q.push_back(k > 9 ? 14 : int'(k));
            end
            P_CHECK: begin
                hit = 0;
                for (int s = 0; s < SLOTS; s++) if (m_vld[s] && m_code[s] == cur) hit = 1;
                q.delete();
                if (hit && full && !bad) begin
                    m_err = 0; m_phase = P_OPEN;
                end else begin
                    if (m_err < MAX_ERR) m_err++;
                    if (m_err == MAX_ERR) begin m_phase = P_LOCK; m_elapsed = 0; end
                    else m_phase = P_IDLE;
                end
            end
            default: begin
                m_elapsed++;
                if (m_elapsed == LOCK_CYC) begin m_phase = P_IDLE; m_err = 0; m_elapsed = 0; end
            end
        endcase
    endtask

    // One clock cycle: apply inputs, advance model, sample after the edge, compare
    task automatic drive(input logic c, input logic md, input logic [1:0] sl,
                         input logic kv, input logic [3:0] k, input logic en, input logic ca);
        logic [32:0] mv, dv;
        bit          mled;
        clr = c; mode = md; slot_sel = sl; key_valid = kv; key_in = k; enter = en; cancel = ca;
        model_step(c, md, sl, kv, k, en, ca);
        @(posedge clk);
        #1;
        mled = (m_phase == P_LOCK) && (((m_elapsed / FLASH_HALF) % 2) == 0);
        mv = {m_pack(), m_phase == P_OPEN, m_ok, m_rej, 4'(m_err), m_phase == P_LOCK, mled};
        dv = {disp, unlocked, set_ok, set_rej, err_cnt, locked_out, led};
        chk("model", 48'(dv), 48'(mv));
        clr = 0; key_valid = 0; enter = 0; cancel = 0;
    endtask

    task automatic rst();                                          drive(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic nop();                                          drive(0, 1, 0, 0, 0, 0, 0); endtask
    task automatic ent(input logic md, input logic [1:0] sl);      drive(0, md, sl, 0, 0, 1, 0); endtask
    task automatic key(input logic md, input logic [1:0] sl, input logic [3:0] k);
        drive(0, md, sl, 1, k, 0, 0);
    endtask
    task automatic code6(input logic md, input logic [1:0] sl, input logic [23:0] c);
        for (int i = 0; i < 6; i++) key(md, sl, c[20 - 4*i +: 4]);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        clr, mode;
        logic [1:0]  slot;
        logic        kv;
        logic [3:0]  key;
        logic        en, ca;
        logic [23:0] e_disp;
        logic        e_unl, e_ok, e_rej;
        logic [3:0]  e_err;
    } vec_t;

    function automatic vec_t row(int c, int md, int sl, int kv, int k, int en, int ca,
                                 logic [23:0] d, int u, int ok, int rj, int er);
        vec_t v;
        v.clr = 1'(c); v.mode = 1'(md); v.slot = 2'(sl); v.kv = 1'(kv); v.key = 4'(k);
        v.en = 1'(en); v.ca = 1'(ca); v.e_disp = d; v.e_unl = 1'(u); v.e_ok = 1'(ok);
        v.e_rej = 1'(rj); v.e_err = 4'(er);
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   lk, toggles;
        logic prev;

        //                clr md sl kv key en ca   disp        unl ok rej err
        tbl.push_back(row(1, 0, 0, 0, 0,  0, 0, 24'hFFFFFF, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 1,  0, 0, 24'hFFFFF1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 2,  0, 0, 24'hFFFF12, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 3,  0, 0, 24'hFFF123, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 4,  0, 0, 24'hFF1234, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 5,  0, 0, 24'hF12345, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 6,  0, 0, 24'h123456, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0,  1, 0, 24'hFFFFFF, 0, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0,  0, 0, 24'hFFFFFF, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 1, 1,  0, 0, 24'hFFFFF1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 1, 2,  0, 0, 24'hFFFF12, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 1, 3,  0, 0, 24'hFFF123, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 1, 4,  0, 0, 24'hFF1234, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 1, 5,  0, 0, 24'hF12345, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 1, 6,  0, 0, 24'h123456, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 0, 0,  1, 0, 24'h123456, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 0, 0,  0, 0, 24'hFFFFFF, 1, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 1, 10, 0, 0, 24'hFFFFFE, 1, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 0, 0,  0, 1, 24'hFFFFFF, 1, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 0, 0,  1, 0, 24'hFFFFFF, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 1, 1,  0, 0, 24'hFFFFF1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 1, 2,  0, 0, 24'hFFFF12, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 1, 3,  0, 0, 24'hFFF123, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 1, 4,  0, 0, 24'hFF1234, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 1, 5,  0, 0, 24'hF12345, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 1, 10, 0, 0, 24'h12345E, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0,  1, 0, 24'hFFFFFF, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 0, 0, 0,  1, 0, 24'hFFFFFF, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 0, 0,  0, 0, 24'hFFFFFF, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 0, 1, 7,  0, 0, 24'hFFFFF7, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 0, 1, 8,  1, 1, 24'hFFFFFF, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 0, 0, 0,  0, 0, 24'hFFFFFF, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 3, 1, 3,  1, 0, 24'hFFFFFF, 0, 0, 1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].mode, tbl[i].slot, tbl[i].kv, tbl[i].key, tbl[i].en, tbl[i].ca);
            chk($sformatf("row%0d disp", i),    48'(disp),     48'(tbl[i].e_disp));
            chk($sformatf("row%0d unlocked", i), 48'(unlocked), 48'(tbl[i].e_unl));
            chk($sformatf("row%0d set_ok", i),  48'(set_ok),   48'(tbl[i].e_ok));
            chk($sformatf("row%0d set_rej", i), 48'(set_rej),  48'(tbl[i].e_rej));
            chk($sformatf("row%0d err_cnt", i), 48'(err_cnt),  48'(tbl[i].e_err));
        end

        // Lockout: three wrong codes, then exact duration, flashing, ignored keys
        rst();
        for (int a = 1; a <= MAX_ERR; a++) begin
            code6(1, 0, 24'h000000);
            ent(1, 0);
            chk("lk check locked", 48'(locked_out), 48'(0));
            nop();
            chk($sformatf("lk err step %0d", a), 48'(err_cnt), 48'(a));
        end
        chk("lk entered", 48'(locked_out), 48'(1));
        chk("lk led start", 48'(led), 48'(1));
        lk = 1; toggles = 0; prev = led;
        for (int t = 0; t < LOCK_CYC + 10 && locked_out; t++) begin
            drive(0, 1, 0, 1, 4'd5, 1'((t % 7) == 3), 1'((t % 11) == 4));
            if (locked_out) lk++;
            if (locked_out && led != prev) toggles++;
            prev = led;
            chk("lk keys ignored", 48'(disp), 48'(24'hFFFFFF));
        end
        chk("lk exited", 48'(locked_out), 48'(0));
        chk("lk length", 48'(lk), 48'(LOCK_CYC));
        chk("lk led toggles", 48'(toggles), 48'((LOCK_CYC - 1) / FLASH_HALF));
        chk("lk led off", 48'(led), 48'(0));
        chk("lk err cleared", 48'(err_cnt), 48'(0));

        // clr in the middle of lockout, together with all strobes
        for (int a = 0; a < MAX_ERR; a++) begin ent(1, 0); nop(); end
        chk("clr pre locked", 48'(locked_out), 48'(1));
        repeat (8) nop();
        drive(1, 1, 0, 1, 4'd3, 1, 1);
        chk("clr locked_out", 48'(locked_out), 48'(0));
        chk("clr led", 48'(led), 48'(0));
        chk("clr err", 48'(err_cnt), 48'(0));
        chk("clr disp", 48'(disp), 48'(24'hFFFFFF));
        chk("clr unlocked", 48'(unlocked), 48'(0));
        nop();
        chk("clr stays idle", 48'(locked_out), 48'(0));

        // Slot protection and the re-programming path
        code6(0, 0, 24'h111111); ent(0, 0);
        chk("slot0 first set", 48'(set_ok), 48'(1));
        code6(0, 0, 24'h222222); ent(0, 0);
        chk("slot0 reset rej", 48'(set_rej), 48'(1));
        chk("slot0 reset ok", 48'(set_ok), 48'(0));
        code6(0, 2, 24'h999999); ent(0, 2);
        chk("slot2 set", 48'(set_ok), 48'(1));
        code6(1, 0, 24'h999999); ent(1, 0);
        chk("999999 check cycle", 48'(unlocked), 48'(0));
        nop();
        chk("999999 unlock", 48'(unlocked), 48'(1));
        code6(0, 0, 24'h654321); ent(0, 0);
        chk("reprogram set_ok", 48'(set_ok), 48'(1));
        chk("reprogram stays open", 48'(unlocked), 48'(1));
        ent(1, 0);
        chk("relock", 48'(unlocked), 48'(0));
        code6(1, 0, 24'h111111); ent(1, 0); nop();
        chk("old code refused", 48'(unlocked), 48'(0));
        chk("old code err", 48'(err_cnt), 48'(1));
        code6(1, 0, 24'h654321); ent(1, 0); nop();
        chk("new code unlock", 48'(unlocked), 48'(1));
        chk("new code err clr", 48'(err_cnt), 48'(0));
        ent(1, 0);
        for (int i = 0; i < 5; i++) key(1, 0, 4'd9);
        ent(1, 0); nop();
        chk("5 digit refused", 48'(unlocked), 48'(0));
        chk("5 digit err", 48'(err_cnt), 48'(1));

        // Randomised traffic, compared cycle by cycle against the model
        rst();
        for (int n = 0; n < 3000; n++) begin
            logic       rc, rm, rkv, ren, rca;
            logic [1:0] rs;
            logic [3:0] rk;
            rc  = ($urandom_range(0, 199) == 0);
            rm  = 1'($urandom_range(0, 1));
            rs  = 2'($urandom_range(0, 3));
            rkv = 1'($urandom_range(0, 1));
            rk  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 2));
            ren = ($urandom_range(0, 9) == 0);
            rca = ($urandom_range(0, 24) == 0);
            drive(rc, rm, rs, rkv, rk, ren, rca);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
